// File: rtl/pipe_stage_reg_if.sv
// Valid/ready data channel between pipeline stages.
// master drives valid/data and samples ready; slave does the opposite.
interface pipe_stage_reg_if #(
  parameter int N = 64
);
  logic         valid;
  logic         ready;
  logic [N-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshaking and a 2-entry skid
// buffer. Every output is a flop, so ready never ripples combinationally
// through a chain of stages. A synchronous flush drops everything held.
module pipe_stage_reg #(
  parameter int           N           = 64,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic                clk,
  input  logic                reset,   // asynchronous, active low
  input  logic                flush,
  pipe_stage_reg_if.slave     up,      // d / in_valid / in_ready
  pipe_stage_reg_if.master    dn,      // q / out_valid / out_ready
  output logic [1:0]          count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] main_r;
  logic [N-1:0] skid_r;
  logic         out_valid_r;
  logic         in_ready_r;
  logic [1:0]   count_r;

  logic         accept;
  logic         emit;

  // Handshake events use only registered ready/valid, keeping the
  // ready path one flop deep.
  assign accept = up.valid & in_ready_r;
  assign emit   = out_valid_r & dn.ready;

  assign up.ready = in_ready_r;
  assign dn.valid = out_valid_r;
  assign dn.data  = main_r;
  assign count    = count_r;

  // Occupancy FSM; flags are registered alongside the state so they
  // always match it. Flush leaves main/skid untouched, q is don't-care
  // while out_valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      main_r      <= RESET_VALUE;
      skid_r      <= RESET_VALUE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      count_r     <= 2'd0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      count_r     <= 2'd0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state       <= FULL;
            main_r      <= up.data;
            out_valid_r <= 1'b1;
            count_r     <= 2'd1;
          end
        end
        FULL: begin
          if (accept && emit) begin
            // pass-through: head leaves, new word becomes head
            main_r <= up.data;
          end else if (accept) begin
            // downstream stalled: park the new word behind the head
            state      <= SKID;
            skid_r     <= up.data;
            in_ready_r <= 1'b0;
            count_r    <= 2'd2;
          end else if (emit) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            count_r     <= 2'd0;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain case exists
          if (emit) begin
            state      <= FULL;
            main_r     <= skid_r;
            in_ready_r <= 1'b1;
            count_r    <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          count_r     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random stream, with a
// queue scoreboard filled on accept and drained/compared on emit.
module tb_pipe_stage_reg;

  localparam int N = 64;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic [1:0]   count;

  pipe_stage_reg_if #(.N(N)) up_if ();
  pipe_stage_reg_if #(.N(N)) dn_if ();

  pipe_stage_reg #(.N(N), .RESET_VALUE('0)) dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .count (count)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] sb[$];
  logic         mon_emit;
  logic         mon_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference occupancy: reset wipes the model at once, like the DUT.
  always @(negedge rst_n) sb.delete();

  // Scoreboard: decide accept/emit from the model's own occupancy and
  // compare every emitted word against the oldest expected one.
  always @(posedge clk) begin
    if (rst_n) begin
      mon_emit = (sb.size() > 0) && dn_if.ready;
      mon_acc  = up_if.valid && (sb.size() < 2) && !flush;
      if (mon_emit) begin
        checks++;
        if (dn_if.valid !== 1'b1 || dn_if.data !== sb[0]) begin
          errors++;
          $display("FAIL emit: q=%h out_valid=%b, expected q=%h out_valid=1",
                   dn_if.data, dn_if.valid, sb[0]);
        end
        void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (mon_acc) sb.push_back(up_if.data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dn_if.data !== '0 || dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || count !== 2'd0) begin
      errors++;
      $display("FAIL reset_during: q=%h ov=%b ir=%b cnt=%0d, expected 0/0/1/0",
               dn_if.data, dn_if.valid, up_if.ready, count);
    end
    #39 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dn_if.data !== '0 || dn_if.valid !== 1'b0 || up_if.ready !== 1'b1 || count !== 2'd0) begin
      errors++;
      $display("FAIL reset_after: q=%h ov=%b ir=%b cnt=%0d, expected 0/0/1/0",
               dn_if.data, dn_if.valid, up_if.ready, count);
    end
  endtask

  task automatic test_stream();
    logic [N-1:0] w1, w2;
    w1 = 64'h0123456789abcdef;
    w2 = 64'h10cac01ac0cac01a;
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1; up_if.data = w1;
    tick();
    checks++;
    if (dn_if.data !== w1 || dn_if.valid !== 1'b1 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_w1: q=%h ov=%b ir=%b, expected q=%h ov=1 ir=1",
               dn_if.data, dn_if.valid, up_if.ready, w1);
    end
    up_if.data = w2;
    tick();
    checks++;
    if (dn_if.data !== w2 || dn_if.valid !== 1'b1 || up_if.ready !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL stream_w2: q=%h ov=%b ir=%b cnt=%0d, expected q=%h ov=1 ir=1 cnt=1",
               dn_if.data, dn_if.valid, up_if.ready, count, w2);
    end
    up_if.valid = 1'b0;
    tick();
    checks++;
    if (count !== 2'd0 || dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: cnt=%0d ov=%b, expected 0/0", count, dn_if.valid);
    end
  endtask

  task automatic test_skid();
    logic [N-1:0] a, b, c;
    a = 64'h21acacacacacacaa;
    b = 64'h3234123412341230;
    c = 64'h4afafafafafafafa;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = a;
    tick();
    up_if.data = b;
    tick();
    up_if.data = c;
    tick();
    tick();
    checks++;
    if (count !== 2'd2 || up_if.ready !== 1'b0 || dn_if.data !== a || dn_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_full: cnt=%0d ir=%b q=%h ov=%b, expected cnt=2 ir=0 q=%h ov=1",
               count, up_if.ready, dn_if.data, dn_if.valid, a);
    end
    dn_if.ready = 1'b1;
    tick();
    checks++;
    if (dn_if.data !== b || up_if.ready !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL skid_drain_b: q=%h ir=%b cnt=%0d, expected q=%h ir=1 cnt=1",
               dn_if.data, up_if.ready, count, b);
    end
    tick();
    up_if.valid = 1'b0;
    checks++;
    if (dn_if.data !== c || dn_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain_c: q=%h ov=%b, expected q=%h ov=1", dn_if.data, dn_if.valid, c);
    end
    tick();
    checks++;
    if (count !== 2'd0 || dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL skid_end: cnt=%0d ov=%b, expected 0/0", count, dn_if.valid);
    end
  endtask

  task automatic test_pass_through();
    logic [N-1:0] a, e;
    a = 64'h21acacacacacacaa;
    e = 64'h5123456789abcdef;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = a;
    tick();
    dn_if.ready = 1'b1; up_if.data = e;
    tick();
    up_if.valid = 1'b0;
    checks++;
    if (count !== 2'd1 || dn_if.data !== e || dn_if.valid !== 1'b1) begin
      errors++;
      $display("FAIL pass_through: cnt=%0d q=%h ov=%b, expected cnt=1 q=%h ov=1",
               count, dn_if.data, dn_if.valid, e);
    end
    tick();
    checks++;
    if (count !== 2'd0) begin
      errors++;
      $display("FAIL pass_drain: cnt=%0d, expected 0", count);
    end
  endtask

  task automatic test_flush();
    logic [N-1:0] f;
    f = 64'h60cac01ac0cac01a;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 64'h1111;
    tick();
    up_if.data = 64'h2222;
    tick();
    checks++;
    if (count !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup: cnt=%0d, expected 2", count);
    end
    flush = 1'b1; up_if.data = f;
    tick();
    flush = 1'b0; up_if.valid = 1'b0;
    checks++;
    if (dn_if.valid !== 1'b0 || count !== 2'd0 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: ov=%b cnt=%0d ir=%b, expected 0/0/1",
               dn_if.valid, count, up_if.ready);
    end
    dn_if.ready = 1'b1;
    tick();
    tick();
    checks++;
    if (dn_if.valid !== 1'b0 || dn_if.data === f) begin
      errors++;
      $display("FAIL flush_dropped: ov=%b q=%h, expected ov=0 and q not %h",
               dn_if.valid, dn_if.data, f);
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] g;
    g = 64'h9afafafafafafafa;
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 64'h7777;
    tick();
    up_if.data = 64'h8888;
    tick();
    up_if.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dn_if.valid !== 1'b0 || count !== 2'd0 || dn_if.data !== '0 || up_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ov=%b cnt=%0d q=%h ir=%b, expected 0/0/0/1",
               dn_if.valid, count, dn_if.data, up_if.ready);
    end
    #1 rst_n = 1'b1;
    tick();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1; up_if.data = g;
    tick();
    up_if.valid = 1'b0;
    checks++;
    if (dn_if.data !== g || dn_if.valid !== 1'b1 || count !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_push: q=%h ov=%b cnt=%0d, expected q=%h ov=1 cnt=1",
               dn_if.data, dn_if.valid, count, g);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      up_if.valid = 1'($urandom_range(0, 3) != 0);
      up_if.data  = {$urandom, $urandom};
      dn_if.ready = 1'($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if (count !== 2'(sb.size()) || up_if.ready !== (sb.size() < 2) ||
          dn_if.valid !== (sb.size() > 0)) begin
        errors++;
        $display("FAIL random_occupancy[%0d]: cnt=%0d ir=%b ov=%b, expected cnt=%0d",
                 i, count, up_if.ready, dn_if.valid, sb.size());
      end
    end
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (count !== 2'd0 || sb.size() != 0) begin
      errors++;
      $display("FAIL random_drain: cnt=%0d model=%0d, expected 0", count, sb.size());
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_pass_through();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
